// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl -- pipeline hazard controller for the 5-stage RISC-V core.
//
// Resolves the hazards that forwarding cannot: load-use stalls, taken
// branch/jump flushes and data-memory wait states. A watchdog traps a data
// memory that stays busy for MEM_TIMEOUT consecutive cycles into HALT.
//
// Parameters:
//   MEM_TIMEOUT  busy cycles tolerated before the trap (1..255, default 16)
//
// Optional feature macro:
//   HAZARD_PERF_CNT_EN  enables stall_cnt / flush_cnt / lu_cnt; when it is
//                       undefined the three ports are tied to zero.
//
// Ports:
//   clk, rst                  core clock, synchronous active-high reset
//   id_rs1, id_rs2            source registers of the ID instruction
//   id_use_rs1, id_use_rs2    ID instruction really reads rs1 / rs2
//   ex_mem_read, ex_rd        EX instruction is a load / its destination
//   ex_redirect               taken branch or jump resolved in EX
//   me_mem_req, me_mem_ready  MEM data access pending / completing
//   pc_stall .. ex_me_stall   hold enables of PC and pipeline registers
//   if_id_flush, id_ex_flush  insert NOP into IF/ID / ID/EX
//   me_wb_bubble              insert NOP into ME/WB
//   mem_err                   sticky memory-timeout flag
//   stall_cnt, flush_cnt, lu_cnt  32-bit performance counters
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        ex_redirect,
    input  logic        me_mem_req,
    input  logic        me_mem_ready,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        id_ex_stall,
    output logic        ex_me_stall,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        me_wb_bubble,
    output logic        mem_err,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
    output logic [31:0] lu_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    // Counter value seen during the last tolerated busy cycle.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 32'd1);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [7:0] wait_cnt_r;
    logic [7:0] wait_cnt_nxt_s;
    logic       load_use_s;
    logic       mem_busy_s;

    assign load_use_s = ex_mem_read && (ex_rd != 5'd0) &&
                        ((id_use_rs1 && (ex_rd == id_rs1)) ||
                         (id_use_rs2 && (ex_rd == id_rs2)));
    assign mem_busy_s = me_mem_req && !me_mem_ready;

    // State and watchdog counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= 8'd0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end

    // Next state. The counter holds the number of busy cycles already seen,
    // so the busy cycle that finds WAIT_LAST is the MEM_TIMEOUT-th one.
    // The first busy cycle is spent in RUN, hence the check there as well
    // (it only fires for MEM_TIMEOUT == 1). A ready never counts as busy,
    // so ready in the expiry cycle naturally returns to RUN.
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        case (state_r)
            ST_RUN, ST_MEM_WAIT: begin
                if (mem_busy_s) begin
                    if (wait_cnt_r == WAIT_LAST) begin
                        state_nxt_s    = ST_HALT;
                        wait_cnt_nxt_s = 8'd0;
                    end else begin
                        state_nxt_s    = ST_MEM_WAIT;
                        wait_cnt_nxt_s = wait_cnt_r + 8'd1;
                    end
                end else begin
                    // Completion (or a withdrawn request) ends the wait.
                    state_nxt_s    = ST_RUN;
                    wait_cnt_nxt_s = 8'd0;
                end
            end
            ST_HALT: begin
                state_nxt_s    = ST_HALT;
                wait_cnt_nxt_s = 8'd0;
            end
            default: begin
                state_nxt_s    = ST_RUN;
                wait_cnt_nxt_s = 8'd0;
            end
        endcase
    end

    // Control outputs, highest priority first.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_me_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        me_wb_bubble = 1'b0;
        mem_err      = 1'b0;
        if (rst) begin
            // Keep NOPs flowing into the front of the pipe during reset.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (state_r == ST_HALT) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_me_stall  = 1'b1;
            me_wb_bubble = 1'b1;
            mem_err      = 1'b1;
        end else if (mem_busy_s) begin
            // EX holds, so any redirect is re-presented after release.
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_me_stall  = 1'b1;
            me_wb_bubble = 1'b1;
        end else if (ex_redirect) begin
            // Squashes the ID instruction, so it beats load-use.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use_s) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            pc_stall = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;
    logic [31:0] lu_cnt_r;
    logic        lu_issue_s;

    // A load-use stall is issued only when nothing of higher priority wins.
    assign lu_issue_s = !rst && (state_r != ST_HALT) && !mem_busy_s &&
                        !ex_redirect && load_use_s;

    // Free-running, wrapping performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
            lu_cnt_r    <= 32'd0;
        end else begin
            stall_cnt_r <= stall_cnt_r + {31'd0, pc_stall};
            flush_cnt_r <= flush_cnt_r + {31'd0, if_id_flush};
            lu_cnt_r    <= lu_cnt_r + {31'd0, lu_issue_s};
        end
    end

    assign stall_cnt = rst ? 32'd0 : stall_cnt_r;
    assign flush_cnt = rst ? 32'd0 : flush_cnt_r;
    assign lu_cnt    = rst ? 32'd0 : lu_cnt_r;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
    assign lu_cnt    = 32'd0;
`endif

endmodule
